// File: rtl/regfile_dumper_pkg.sv
// Shared definitions for the register-file dumper and the processor wrapper:
// state encoding, register count and register-index width.
package regfile_dumper_pkg;

  localparam int NUM_REGS  = 32;
  localparam int REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_READ = 3'd2,
    ST_SEND = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/regfile_dumper_if.sv
// Dump stream: one register index/value pair per valid/ready handshake.
interface regfile_dumper_if
  import regfile_dumper_pkg::*;
#(
  parameter int DATA_WIDTH = 32
);

  logic                  out_valid;
  logic                  out_ready;
  reg_idx_t              out_reg;
  logic [DATA_WIDTH-1:0] out_data;

  modport master (
    output out_valid,
    output out_reg,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_reg,
    input  out_data,
    output out_ready
  );

endinterface

// File: rtl/regfile_dumper.sv
// Lets the processor run for a programmed number of cycles, then takes over
// regfile read port A and streams every register out over the dump interface.
//
// state | meaning
// IDLE  | waiting for start, processor halted
// RUN   | processor enabled until the run counter reaches the latched count
// READ  | port A addressed with the current index, value captured at the edge
// SEND  | captured index/value presented until the sink accepts it
// DONE  | one-cycle completion pulse
module regfile_dumper
  import regfile_dumper_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = regfile_dumper_pkg::NUM_REGS,
  parameter int CNT_WIDTH  = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  run_cycles,
  output logic                  cpu_enable,
  output logic                  test_mode,
  output reg_idx_t              dbg_readRegA,
  input  logic [DATA_WIDTH-1:0] data_readRegA,
  regfile_dumper_if.master      dump,
  output logic                  busy,
  output logic                  done
);

  localparam reg_idx_t LAST_IDX = reg_idx_t'(NUM_REGS - 1);

  state_t                state;
  state_t                state_nxt;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [CNT_WIDTH-1:0]  run_lat;
  reg_idx_t              idx;
  reg_idx_t              reg_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  out_valid;
  logic                  run_end;
  logic                  last_reg;
  logic                  hs;

  // The counter stops at the latched value, so a full-scale count never wraps.
  assign run_end  = (cnt == run_lat);
  assign last_reg = (idx == LAST_IDX);
  assign hs       = out_valid && dump.out_ready;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and state-driven outputs
  always_comb begin
    state_nxt  = state;
    cpu_enable = 1'b0;
    test_mode  = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // The terminal-count cycle already has the processor halted, so a
        // count of N gives exactly N enabled cycles.
        cpu_enable = !run_end;
        if (run_end) state_nxt = ST_READ;
      end
      ST_READ: begin
        test_mode = 1'b1;
        state_nxt = ST_SEND;
      end
      ST_SEND: begin
        test_mode = 1'b1;
        out_valid = 1'b1;
        if (dump.out_ready) state_nxt = last_reg ? ST_DONE : ST_READ;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Run-length latch and cycle counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run_lat <= '0;
      cnt     <= '0;
    end else if (state == ST_IDLE && start) begin
      run_lat <= run_cycles;
      cnt     <= '0;
    end else if (state == ST_RUN && !run_end) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Dump index and captured register value
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx    <= '0;
      reg_q  <= '0;
      data_q <= '0;
    end else begin
      if (state == ST_RUN && run_end) idx <= '0;
      if (state == ST_READ) begin
        reg_q  <= idx;
        data_q <= data_readRegA;
      end
      if (hs && !last_reg) idx <= idx + 1'b1;
    end
  end

  assign dbg_readRegA   = test_mode ? idx : '0;
  assign dump.out_valid = out_valid;
  assign dump.out_reg   = reg_q;
  assign dump.out_data  = data_q;

endmodule

// File: tb/tb_regfile_dumper.sv
// Directed bench for regfile_dumper: the stimulus pushes the expected dump
// into a scoreboard and a monitor pops and compares on every handshake.
module tb_regfile_dumper;
  import regfile_dumper_pkg::*;

  localparam int DW = 32;
  localparam int CW = 10;
  localparam int NR = regfile_dumper_pkg::NUM_REGS;

  typedef struct packed {
    logic [4:0]    idx;
    logic [DW-1:0] data;
  } exp_t;

  logic          clock      = 1'b0;
  logic          reset      = 1'b1;
  logic          start      = 1'b0;
  logic [CW-1:0] run_cycles = '0;
  logic          cpu_enable;
  logic          test_mode;
  logic          busy;
  logic          done;
  logic [4:0]    dbg_readRegA;
  logic [DW-1:0] data_readRegA;

  logic [DW-1:0] regs [NR];
  exp_t          sb [$];
  exp_t          mon_e;

  int checks    = 0;
  int errors    = 0;
  int en_cycles = 0;
  int done_cnt  = 0;
  int hs_cnt    = 0;
  int done_base = 0;
  int hs_base   = 0;
  int cyc       = 0;

  regfile_dumper_if #(.DATA_WIDTH(DW)) dump ();

  regfile_dumper #(
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR),
    .CNT_WIDTH  (CW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .run_cycles    (run_cycles),
    .cpu_enable    (cpu_enable),
    .test_mode     (test_mode),
    .dbg_readRegA  (dbg_readRegA),
    .data_readRegA (data_readRegA),
    .dump          (dump),
    .busy          (busy),
    .done          (done)
  );

  // Combinational regfile model behind read port A
  assign data_readRegA = regs[dbg_readRegA];

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: activity counters and scoreboard compare on each handshake
  always @(negedge clock) begin
    if (!reset) begin
      if (cpu_enable) en_cycles++;
      if (done) done_cnt++;
      if (dump.out_valid && dump.out_ready) begin
        hs_cnt++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_hs: got reg %0d data %0h expected no transfer",
                   dump.out_reg, dump.out_data);
        end else begin
          mon_e = sb.pop_front();
          chk("hs_reg", 64'(dump.out_reg), 64'(mon_e.idx));
          chk("hs_data", 64'(dump.out_data), 64'(mon_e.data));
          if (dump.out_reg == 5'd7)  chk("r7_value", 64'(dump.out_data), 64'h0000_0000_DEAD_BEEF);
          if (dump.out_reg == 5'd31) chk("r31_value", 64'(dump.out_data), 64'h0000_0000_FFFF_FFFF);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic [CW-1:0] rc);
    tick();
    en_cycles  = 0;
    done_base  = done_cnt;
    hs_base    = hs_cnt;
    run_cycles = rc;
    start      = 1'b1;
    for (int i = 0; i < NR; i++) sb.push_back({5'(i), regs[i]});
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name, output int n);
    n = 0;
    while (done_cnt == done_base && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_done_seen"}, 64'(done_cnt != done_base), 64'd1);
    repeat (3) tick();
  endtask

  // mode 0: wait for SEND of register r; mode 1: wait for READ of register r
  task automatic wait_reg(input logic [4:0] r, input bit mode, input int budget, input string name);
    int n = 0;
    logic hit;
    hit = mode ? (test_mode && !dump.out_valid && dbg_readRegA == r)
               : (dump.out_valid && dump.out_reg == r);
    while (!hit && n < budget) begin
      tick();
      n++;
      hit = mode ? (test_mode && !dump.out_valid && dbg_readRegA == r)
                 : (dump.out_valid && dump.out_reg == r);
    end
    chk({name, "_reached"}, 64'(hit), 64'd1);
  endtask

  task automatic end_phase(input string name, input int exp_en);
    chk({name, "_en_cycles"}, 64'(en_cycles), 64'(exp_en));
    chk({name, "_done_pulses"}, 64'(done_cnt - done_base), 64'd1);
    chk({name, "_handshakes"}, 64'(hs_cnt - hs_base), 64'(NR));
    chk({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
    chk({name, "_idle"}, 64'({busy, test_mode, cpu_enable}), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) regs[i] = {8'hA5, 8'(i), 8'h00, 8'd255 - 8'(i)};
    regs[7]  = 32'hDEAD_BEEF;
    regs[31] = 32'hFFFF_FFFF;
    dump.out_ready = 1'b1;

    #3;
    chk("reset_ctrl", 64'({cpu_enable, test_mode, busy, done, dump.out_valid}), 64'd0);
    chk("reset_idx", 64'({dump.out_reg, dbg_readRegA}), 64'd0);
    chk("reset_data", 64'(dump.out_data), 64'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // run 5 cycles, free-flowing sink: 6 RUN + 2 per register + DONE
    do_start(10'd5);
    wait_done(5 + 2 * NR + 20, "t1", cyc);
    chk("t1_latency", 64'(cyc), 64'(6 + 2 * NR + 1));
    end_phase("t1", 5);

    // sink stalls for 10 cycles on register 3
    do_start(10'd1);
    wait_reg(5'd3, 1'b1, 40, "t2_read3");
    dump.out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t2_stall_hold", 64'({dump.out_valid, dump.out_reg, dump.out_data}),
          64'({1'b1, 5'd3, regs[3]}));
    end
    dump.out_ready = 1'b1;
    tick();
    chk("t2_advance", 64'({test_mode, dump.out_valid, dbg_readRegA}), 64'({1'b1, 1'b0, 5'd4}));
    wait_done(2 * NR + 20, "t2", cyc);
    end_phase("t2", 1);

    // zero-length run: straight through RUN to READ of register 0
    do_start(10'd0);
    chk("t3_run", 64'({busy, cpu_enable, test_mode}), 64'({1'b1, 1'b0, 1'b0}));
    tick();
    chk("t3_read0", 64'({test_mode, dump.out_valid, dbg_readRegA}), 64'({1'b1, 1'b0, 5'd0}));
    wait_done(2 * NR + 20, "t3", cyc);
    end_phase("t3", 0);

    // reset in the middle of the dump, then a fresh full sequence
    do_start(10'd2);
    wait_reg(5'd12, 1'b0, 60, "t4_send12");
    reset = 1'b1;
    #1;
    chk("t4_abort_ctrl", 64'({cpu_enable, test_mode, busy, done, dump.out_valid}), 64'd0);
    chk("t4_abort_idx", 64'({dump.out_reg, dbg_readRegA}), 64'd0);
    chk("t4_abort_data", 64'(dump.out_data), 64'd0);
    sb.delete();
    tick();
    tick();
    reset = 1'b0;
    done_base = done_cnt;
    hs_base   = hs_cnt;
    repeat (6) tick();
    chk("t4_quiet", 64'({busy, 16'(done_cnt - done_base), 16'(hs_cnt - hs_base)}), 64'd0);
    do_start(10'd2);
    wait_done(2 + 2 * NR + 20, "t4", cyc);
    end_phase("t4", 2);

    // extra start pulses during RUN and SEND are ignored
    do_start(10'd3);
    tick();
    run_cycles = 10'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_reg(5'd5, 1'b0, 40, "t5_send5");
    run_cycles = 10'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(2 * NR + 20, "t5", cyc);
    end_phase("t5", 3);
    repeat (10) tick();
    chk("t5_no_rerun", 64'({busy, 16'(done_cnt - done_base), 16'(hs_cnt - hs_base)}),
        64'({1'b0, 16'd1, 16'(NR)}));

    // full-scale run count must not wrap
    do_start(10'd1023);
    wait_done(1023 + 2 * NR + 30, "t6", cyc);
    end_phase("t6", 1023);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
